// File: rtl/outer_in_packer32_pkg.sv
// Shared types and widths for the 32->64 outer_in packer.
// Optional padding of odd-length messages is enabled with OUTER_PACK_FLUSH_EN.
package outer_in_packer32_pkg;

    localparam int HALF_W = 32;
    localparam int WORD_W = 64;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } word_t;

    function automatic word_t pack_word(input logic [HALF_W-1:0] hi,
                                        input logic [HALF_W-1:0] lo,
                                        input logic              last);
        word_t w;
        w.last = last;
        w.data = {hi, lo};
        return w;
    endfunction

endpackage

// File: rtl/outer_in_packer32_if.sv
// Stream bundle used for both the 32-bit host side and the 64-bit outer side.
// A beat moves when isReady & canReceive are both high in the same cycle; the
// sender holds dat/isLast stable while isReady waits, and isReady never looks at canReceive.
interface outer_in_packer32_if #(
    parameter int W = 32
);
    logic [W-1:0] dat;
    logic         isReady;
    logic         canReceive;
    logic         isLast;

    modport master (output dat, output isReady, output isLast, input canReceive);
    modport slave  (input dat, input isReady, input isLast, output canReceive);
endinterface

// File: rtl/outer_in_packer32_fifo.sv
// Small output FIFO (module outer_pack_fifo) holding packed word + isLast.
// Flags are registered from the next-state count; head is read straight from storage.
module outer_pack_fifo #(
    parameter int Width = 65,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntBits = PtrW + 1;
    localparam logic [CntBits-1:0] FullCnt = CntBits'(Depth);

    logic [Width-1:0]   mem_q [Depth];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q, count_d;
    logic               full_q, empty_q;
    logic               do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntBits'(1);
            2'b01:   count_d = count_q - CntBits'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            full_q  <= (count_d == FullCnt);
            empty_q <= (count_d == '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/outer_in_packer32.sv
// Packs pairs of 32-bit host beats (low half first) into 64-bit outer words.
// Define OUTER_PACK_FLUSH_EN to pad an odd final beat to a full word instead of holding it.
module outer_in_packer32
    import outer_in_packer32_pkg::*;
#(
    parameter int FifoDepth = 2,
    parameter int CntW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    outer_in_packer32_if.slave  h32,
    outer_in_packer32_if.master o,
    output logic                err_oddLast,
    output state_t              dbg_state,
    output logic [CntW-1:0]     dbg_pad_cnt
);
    state_t            state_q, state_d;
    logic [HALF_W-1:0] lo_q;
    logic              err_q;
    logic              run_q;
    logic              accept, odd_last, load_lo, push, pop;
    logic              fifo_full, fifo_empty;
    word_t             push_word, head;

    // run_q keeps canReceive low while reset is held and for the first edge after.
    assign h32.canReceive = run_q & ~fifo_full;
    assign accept         = h32.isReady & h32.canReceive;
    assign odd_last       = accept & (state_q == ST_LOW) & h32.isLast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_LOW;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (state_q == ST_HIGH) state_d = ST_LOW;
`ifdef OUTER_PACK_FLUSH_EN
            else if (h32.isLast)    state_d = ST_LOW;
`endif
            else                    state_d = ST_HIGH;
        end
    end

    always_comb begin
        load_lo   = 1'b0;
        push      = 1'b0;
        push_word = '0;
        if (accept) begin
            if (state_q == ST_HIGH) begin
                push      = 1'b1;
                push_word = pack_word(h32.dat, lo_q, h32.isLast);
            end
`ifdef OUTER_PACK_FLUSH_EN
            else if (h32.isLast) begin
                push      = 1'b1;
                push_word = pack_word('0, h32.dat, 1'b1);
            end
`endif
            else begin
                load_lo = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q  <= '0;
            err_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            if (load_lo) lo_q <= h32.dat;
            err_q <= err_q | odd_last;
            run_q <= 1'b1;
        end
    end

`ifdef OUTER_PACK_FLUSH_EN
    logic [CntW-1:0] pad_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          pad_cnt_q <= '0;
        else if (odd_last) pad_cnt_q <= pad_cnt_q + CntW'(1);
    end

    assign dbg_pad_cnt = pad_cnt_q;
`else
    assign dbg_pad_cnt = '0;
`endif

    assign pop = o.isReady & o.canReceive;

    outer_pack_fifo #(
        .Width ($bits(word_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign o.isReady   = ~fifo_empty;
    assign o.dat       = head.data;
    assign o.isLast    = head.last;
    assign err_oddLast = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_outer_in_packer32.sv
// Self-checking bench for outer_in_packer32: directed cases plus a randomized
// message stream, scored against a beat-pairing reference model.
module tb_outer_in_packer32;
    import outer_in_packer32_pkg::*;

    localparam int FifoDepth = 2;
    localparam int CntW      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              err_oddLast;
    state_t            dbg_state;
    logic [CntW-1:0]   dbg_pad_cnt;

    outer_in_packer32_if #(.W(32)) h32 ();
    outer_in_packer32_if #(.W(64)) o ();

    outer_in_packer32 #(.FifoDepth(FifoDepth), .CntW(CntW)) dut (
        .clk         (clk),
        .rst         (rst),
        .h32         (h32),
        .o           (o),
        .err_oddLast (err_oddLast),
        .dbg_state   (dbg_state),
        .dbg_pad_cnt (dbg_pad_cnt)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          vectors    = 0;
    int          miscompares = 0;
    logic [64:0] exp_q [$];
    logic [31:0] pend_q [$];
    logic        err_exp = 1'b0;
    int          acc_cnt = 0;
    int          last_acc_cyc = 0;
    int          sink_mode = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: beats of a message pair up in arrival order, low half first.
    task automatic model_accept(input logic [31:0] d, input logic last);
        acc_cnt++;
        if (pend_q.size() == 0 && last) err_exp = 1'b1;
`ifdef OUTER_PACK_FLUSH_EN
        if (pend_q.size() == 0 && last) begin
            exp_q.push_back({1'b1, 32'h0, d});
            return;
        end
`endif
        pend_q.push_back(d);
        if (pend_q.size() == 2) begin
            exp_q.push_back({last, pend_q[1], pend_q[0]});
            pend_q.delete();
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        err_exp = 1'b0;
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send_beat(input logic [31:0] d, input logic last);
        int  waited = 0;
        bit  done = 0;
        bit  ok = 0;
        h32.dat     = d;
        h32.isLast  = last;
        h32.isReady = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (h32.canReceive) begin
                model_accept(d, last);
                last_acc_cyc = cyc;
                done = 1;
                ok = 1;
            end else if (++waited >= 500) begin
                vectors++;
                miscompares++;
                $display("FAIL beat accept timeout: canReceive=%0b after %0d cycles, expected 1", h32.canReceive, waited);
                h32.isReady = 1'b0;
                done = 1;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            h32.isReady = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain timeout: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- sink ----------------
    initial begin
        o.canReceive = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       o.canReceive = 1'b1;
                1:       o.canReceive = 1'b0;
                2:       o.canReceive = ($urandom_range(0, 1) == 1);
                default: ;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst && o.isReady && o.canReceive) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected word: got %h, expected none", {o.isLast, o.dat});
                end else begin
                    check("word", {o.isLast, o.dat}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int first_cyc;
        int base;
        int beats;
        int len;

        h32.dat     = '0;
        h32.isLast  = 1'b0;
        h32.isReady = 1'b0;

        // Reset values while rst is held low
        repeat (2) @(negedge clk);
        check("rst isReady",    {64'b0, o.isReady},      65'd0);
        check("rst word",       {o.isLast, o.dat},       65'd0);
        check("rst canReceive", {64'b0, h32.canReceive}, 65'd0);
        check("rst err",        {64'b0, err_oddLast},    65'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // T1: one pair, latency and word contents
        send_beat(32'h11111111, 1'b0);
        first_cyc = last_acc_cyc;
        send_beat(32'h22222222, 1'b0);
        @(negedge clk);
        check("t1 latency", 65'(cyc - first_cyc), 65'd2);
        check("t1 word",    {o.isLast, o.dat}, {1'b0, 64'h2222222211111111});
        drain();

        // T2: three beats with isLast on the third
        send_beat(32'hAAAA0001, 1'b0);
        send_beat(32'hBBBB0002, 1'b0);
        send_beat(32'hCCCC0003, 1'b1);
        drain();
        repeat (10) @(negedge clk);
        check("t2 no extra word", {64'b0, o.isReady}, 65'd0);
        check("t2 err", {64'b0, err_oddLast}, {64'b0, err_exp});
        check("t2 err set", {64'b0, err_oddLast}, 65'd1);
        check("t2 state", {64'b0, dbg_state}, (pend_q.size() != 0) ? 65'(ST_HIGH) : 65'(ST_LOW));
        @(posedge clk);
        #1;
        send_beat(32'hDDDD0004, 1'b1);
        drain();

        // T3: sink stalled, FIFO fills and host is throttled
        sink_mode = 1;
        idle(2);
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(32'h30000000 + 32'(i), (i == 5));
            end
        join_none
        repeat (20) @(negedge clk);
        check("t3 canReceive low", {64'b0, h32.canReceive}, 65'd0);
        check("t3 words buffered", 65'(acc_cnt - base), 65'(2 * FifoDepth));
        check("t3 isReady", {64'b0, o.isReady}, 65'd1);

        // T4: pop from a full FIFO while the host is waiting
        @(posedge clk);
        #1;
        sink_mode    = 3;
        o.canReceive = 1'b1;
        @(negedge clk);
        check("t4 no push on pop", {64'b0, h32.canReceive}, 65'd0);
        check("t4 no accept", 65'(acc_cnt - base), 65'(2 * FifoDepth));
        @(posedge clk);
        #1;
        o.canReceive = 1'b0;
        @(negedge clk);
        check("t4 canReceive rises", {64'b0, h32.canReceive}, 65'd1);
        @(posedge clk);
        #1;
        sink_mode = 0;
        wait fork;
        drain();

        // T5: reset while a low half is held
        send_beat(32'h55550001, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("t5 rst isReady",    {64'b0, o.isReady},      65'd0);
        check("t5 rst canReceive", {64'b0, h32.canReceive}, 65'd0);
        check("t5 rst err",        {64'b0, err_oddLast},    65'd0);
        check("t5 rst state",      {64'b0, dbg_state},      65'(ST_LOW));
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5);
        @(negedge clk);
        check("t5 no word", {64'b0, o.isReady}, 65'd0);
        @(posedge clk);
        #1;
        send_beat(32'h66660001, 1'b0);
        send_beat(32'h66660002, 1'b1);
        drain();

        // T6: random even-length messages with random host gaps and sink stalls
        sink_mode = 2;
        beats = 0;
        while (beats < 10000) begin
            len = 2 * $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                send_beat($urandom, (i == len - 1));
                beats++;
            end
        end
        drain();
        check("t6 err", {64'b0, err_oddLast}, {64'b0, err_exp});
        check("t6 err clear", {64'b0, err_oddLast}, 65'd0);
        check("t6 no half held", {64'b0, dbg_state}, 65'(ST_LOW));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
